// File: rtl/mp_adder_pkg.sv
// mp_adder_pkg: shared constants, state encoding and operand/result types
// for the multi-precision adder/subtractor.
//   DATA_W  operand width (unsigned)
//   RES_W   result width, one carry bit above DATA_W
//   CHUNK_W bits processed per clock in the iterative datapath
//   NCHUNK  slices needed to cover RES_W
//   PAD_W   internal working width, NCHUNK whole slices
package mp_adder_pkg;

  localparam int DATA_W  = 1027;
  localparam int RES_W   = DATA_W + 1;
  localparam int CHUNK_W = 128;
  localparam int NCHUNK  = (RES_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W   = NCHUNK * CHUNK_W;
  localparam int CNT_W   = $clog2(NCHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [DATA_W-1:0] operand_t;
  typedef logic [RES_W-1:0]  result_t;
  typedef logic [PAD_W-1:0]  padded_t;

  // Zero-extend an operand to whole slices.
  function automatic padded_t pad_op(input operand_t x);
    return {{(PAD_W - DATA_W){1'b0}}, x};
  endfunction

endpackage

// File: rtl/mp_adder_if.sv
// mp_adder_if: request/response bundle of the multi-precision adder.
//   start     1-cycle request, samples in_a, in_b, subtract
//   subtract  0: a + b, 1: a - b
//   in_a/in_b DATA_W-bit unsigned operands
//   result    RES_W-bit registered sum/difference
//   done      level, high while result is valid
// master: requester side; slave: adder side.
interface mp_adder_if;
  import mp_adder_pkg::*;

  logic     start;
  logic     subtract;
  operand_t in_a;
  operand_t in_b;
  result_t  result;
  logic     done;

  modport master (
    output start, subtract, in_a, in_b,
    input  result, done
  );

  modport slave (
    input  start, subtract, in_a, in_b,
    output result, done
  );

endinterface

// File: rtl/mp_adder_chunk.sv
// mp_adder_chunk: combinational CHUNK_W-bit adder slice with carry in/out.
//   a, b  slice operands
//   cin   carry from the previous (less significant) slice
//   sum   slice sum
//   cout  carry into the next slice
module mp_adder_chunk
  import mp_adder_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);

  logic [CHUNK_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};
  assign sum  = full[CHUNK_W-1:0];
  assign cout = full[CHUNK_W];

endmodule

// File: rtl/mp_adder.sv
// mp_adder: multi-precision adder/subtractor for the RSA datapath.
// Computes in_a + in_b or in_a - in_b (unsigned, DATA_W bits) into a RES_W-bit
// result with a start/done handshake.
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     mp_adder_if.slave (start, subtract, in_a, in_b, result, done)
// Build option MP_ADDER_SINGLE_CYCLE_EN: full-width adder, result and done
// registered on the edge that samples start. Without it (default) one
// CHUNK_W slice is added per clock with a rippled carry register, done rising
// NCHUNK+1 cycles after the start cycle.
// Subtraction is a + ~b + 1 over the zero-extended operands, so a < b yields
// the two's complement with bit RES_W-1 set.
module mp_adder
  import mp_adder_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  mp_adder_if.slave   bus
);

  state_t  state;
  result_t res_q;
  logic    done_q;

`ifdef MP_ADDER_SINGLE_CYCLE_EN

  result_t a_ext;
  result_t b_ext;
  result_t sum_full;

  assign a_ext    = {1'b0, bus.in_a};
  assign b_ext    = bus.subtract ? ~{1'b0, bus.in_b} : {1'b0, bus.in_b};
  assign sum_full = a_ext + b_ext + result_t'(bus.subtract);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            res_q  <= sum_full;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

`else

  padded_t              a_sh;
  padded_t              b_sh;
  padded_t              res_sh;
  logic                 carry;
  logic [CNT_W-1:0]     cnt;
  logic [CHUNK_W-1:0]   slice_sum;
  logic                 slice_cout;

  mp_adder_chunk u_chunk (
    .a    (a_sh[CHUNK_W-1:0]),
    .b    (b_sh[CHUNK_W-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Operand shifters: loaded on an accepted start (b pre-inverted for
  // subtract), then shifted one slice per RUN cycle so slice i sits at bit 0.
  always_ff @(posedge clk) begin
    if (state == RUN) begin
      a_sh <= {{CHUNK_W{1'b0}}, a_sh[PAD_W-1:CHUNK_W]};
      b_sh <= {{CHUNK_W{1'b0}}, b_sh[PAD_W-1:CHUNK_W]};
    end else if (bus.start) begin
      a_sh <= pad_op(bus.in_a);
      b_sh <= bus.subtract ? ~pad_op(bus.in_b) : pad_op(bus.in_b);
    end
  end

  // Control, carry and result shifter: each slice sum enters at the top, so
  // after NCHUNK slices slice 0 has reached bit 0 and padding sits above RES_W.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      carry  <= 1'b0;
      cnt    <= '0;
      res_sh <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= RUN;
            carry  <= bus.subtract;
            cnt    <= '0;
            done_q <= 1'b0;
          end
        end
        RUN: begin
          res_sh <= {slice_sum, res_sh[PAD_W-1:CHUNK_W]};
          carry  <= slice_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(NCHUNK - 1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign res_q = res_sh[RES_W-1:0];

`endif

  assign bus.result = res_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_mp_adder.sv
// tb_mp_adder: directed and randomised checks of mp_adder (either build).
module tb_mp_adder;
  import mp_adder_pkg::*;

`ifdef MP_ADDER_SINGLE_CYCLE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = NCHUNK + 1;
`endif

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  mp_adder_if bus ();

  mp_adder dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input result_t got, input result_t exp);
    int fd;
    checks++;
    if (got !== exp) begin
      errors++;
      fd = -1;
      for (int i = RES_W - 1; i >= 0; i--) begin
        if (got[i] !== exp[i]) begin
          fd = i;
          break;
        end
      end
      $display("FAIL %s: got[127:0]=%h exp[127:0]=%h got[1027]=%b exp[1027]=%b top_diff_bit=%0d",
               tag, got[127:0], exp[127:0], got[RES_W-1], exp[RES_W-1], fd);
    end
  endtask

  function automatic result_t model(input operand_t a, input operand_t b, input logic sub);
    result_t ea;
    result_t eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return sub ? (ea - eb) : (ea + eb);
  endfunction

  function automatic operand_t rnd_op();
    logic [33*32-1:0] w;
    int               k;
    k = $urandom_range(0, 7);
    if (k == 0) return '0;
    if (k == 1) return '1;
    for (int i = 0; i < 33; i++) w[i*32 +: 32] = $urandom;
    return w[DATA_W-1:0];
  endfunction

  // Present a request for one clock, then scramble the inputs.
  task automatic issue(input operand_t a, input operand_t b, input logic sub);
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.subtract = sub;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    bus.subtract = ~sub;
  endtask

  // Count cycles (start cycle = 1) until done, bounded.
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input operand_t a, input operand_t b,
                        input logic sub, input result_t exp);
    int cyc;
    issue(a, b, sub);
    wait_done(1, cyc);
    chk({tag, " latency"}, result_t'(cyc), result_t'(LAT));
    chk(tag, bus.result, exp);
  endtask

  initial begin
    int      cyc;
    operand_t ra;
    operand_t rb;
    logic    rs;
    operand_t ones;
    ones = '1;

    resetn       = 1'b0;
    bus.start    = 1'b0;
    bus.subtract = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    #12;
    chk("reset result", bus.result, '0);
    chk("reset done", result_t'(bus.done), '0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("add 1+1", operand_t'(1), operand_t'(1), 1'b0, result_t'(2));
    run_op("add max+max", ones, ones, 1'b0, {{(RES_W-1){1'b1}}, 1'b0});
    run_op("add chunk carry", operand_t'({128{1'b1}}), operand_t'(1), 1'b0,
           result_t'(1) << 128);
    run_op("add full ripple", ones, operand_t'(1), 1'b0, result_t'(1) << DATA_W);
    run_op("sub 1-1", operand_t'(1), operand_t'(1), 1'b1, '0);
    run_op("sub 5-3", operand_t'(5), operand_t'(3), 1'b1, result_t'(2));
    run_op("sub max-max", ones, ones, 1'b1, '0);
    run_op("sub borrow ripple", operand_t'(1) << 1024, operand_t'(1), 1'b1,
           (result_t'(1) << 1024) - result_t'(1));
    run_op("sub 0-1", '0, operand_t'(1), 1'b1, '1);
    run_op("sub 0-max", '0, ones, 1'b1, {1'b1, {(RES_W-2){1'b0}}, 1'b1});

    repeat (5) @(negedge clk);
    chk("hold done", result_t'(bus.done), result_t'(1));
    chk("hold result", bus.result, {1'b1, {(RES_W-2){1'b0}}, 1'b1});

`ifndef MP_ADDER_SINGLE_CYCLE_EN
    // A second start during RUN must not disturb the operation in flight.
    issue(operand_t'(3), operand_t'(4), 1'b0);
    repeat (3) @(negedge clk);
    bus.in_a     = operand_t'(100);
    bus.in_b     = operand_t'(100);
    bus.subtract = 1'b0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_done(5, cyc);
    chk("run start ignored latency", result_t'(cyc), result_t'(LAT));
    chk("run start ignored result", bus.result, result_t'(7));
`endif

    // Start while DONE: done drops on the next edge (iterative build).
    @(negedge clk);
    bus.in_a     = operand_t'(9);
    bus.in_b     = operand_t'(2);
    bus.subtract = 1'b1;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    chk("b2b done drop", result_t'(bus.done), result_t'(LAT == 1));
    wait_done(1, cyc);
    chk("b2b latency", result_t'(cyc), result_t'(LAT));
    chk("b2b result", bus.result, result_t'(7));

    // Asynchronous reset in the middle of an operation.
    issue(ones, ones, 1'b0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midreset result", bus.result, '0);
    chk("midreset done", result_t'(bus.done), '0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("after reset add", operand_t'(40), operand_t'(2), 1'b0, result_t'(42));

    for (int n = 0; n < 200; n++) begin
      ra = rnd_op();
      rb = rnd_op();
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand %0d", n), ra, rb, rs, model(ra, rb, rs));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
